// File: rtl/regfile_write_sequencer.sv
// Sole owner of the integer register file write port: zero-fills x01..x31 after
// reset, then arbitrates between pipeline writeback and a slow multi-cycle source.
module regfile_write_sequencer #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        slow_valid,
    input  logic [4:0]  slow_rd,
    input  logic [31:0] slow_data,
    output logic        slow_ready,
    output logic        init_busy,
    output logic        rf_wr_ena,
    output logic [4:0]  rf_wr_addr,
    output logic [31:0] rf_wr_data
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t      state_q, state_d;
    logic [4:0]  fill_q, fill_d;
    logic [3:0]  starve_q, starve_d;
    logic        wr_ena_q, wr_ena_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [31:0] wr_data_q, wr_data_d;

    logic force_slow, grant_pipe, grant_slow, in_run;

    always_comb begin
        in_run     = (state_q == RUN);
        force_slow = in_run && slow_valid && (starve_q == LIMIT);
        grant_pipe = in_run && pipe_valid && !force_slow;
        grant_slow = in_run && slow_valid && !grant_pipe;

        state_d   = state_q;
        fill_d    = fill_q;
        starve_d  = starve_q;
        wr_ena_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        if (!in_run) begin
            wr_ena_d  = 1'b1;
            wr_addr_d = fill_q;
            wr_data_d = '0;
            fill_d    = fill_q + 5'd1;
            starve_d  = '0;
            if (fill_q == 5'd31) state_d = RUN;
        end else begin
            // A granted write to x00 still completes the handshake but never enables the port.
            if (grant_pipe) begin
                wr_ena_d  = (pipe_rd != 5'd0);
                wr_addr_d = pipe_rd;
                wr_data_d = pipe_data;
            end else if (grant_slow) begin
                wr_ena_d  = (slow_rd != 5'd0);
                wr_addr_d = slow_rd;
                wr_data_d = slow_data;
            end

            if (grant_slow || !slow_valid) begin
                starve_d = '0;
            end else if (grant_pipe) begin
                starve_d = starve_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            fill_q    <= 5'd1;
            starve_q  <= '0;
            wr_ena_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            starve_q  <= starve_d;
            wr_ena_q  <= wr_ena_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign init_busy  = !in_run;
    assign pipe_stall = !in_run || force_slow;
    assign slow_ready = grant_slow;
    assign rf_wr_ena  = wr_ena_q;
    assign rf_wr_addr = wr_addr_q;
    assign rf_wr_data = wr_data_q;

endmodule

// File: tb/tb_regfile_write_sequencer.sv
// Bench for regfile_write_sequencer: directed scenarios plus random traffic,
// compared cycle by cycle against a transaction-level reference model.
module tb_regfile_write_sequencer;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        pipe_stall;
    logic        slow_valid;
    logic [4:0]  slow_rd;
    logic [31:0] slow_data;
    logic        slow_ready;
    logic        init_busy;
    logic        rf_wr_ena;
    logic [4:0]  rf_wr_addr;
    logic [31:0] rf_wr_data;

    regfile_write_sequencer #(.STARVE_LIMIT(LIMIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_rd    (pipe_rd),
        .pipe_data  (pipe_data),
        .pipe_stall (pipe_stall),
        .slow_valid (slow_valid),
        .slow_rd    (slow_rd),
        .slow_data  (slow_data),
        .slow_ready (slow_ready),
        .init_busy  (init_busy),
        .rf_wr_ena  (rf_wr_ena),
        .rf_wr_addr (rf_wr_addr),
        .rf_wr_data (rf_wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: fill progress, slow-source wait time, expected write port.
    bit          m_init;
    int          m_fill;
    int          m_wait;
    logic        m_ena;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] rf_model [32];
    int          stall_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_init = 1'b1;
        m_fill = 1;
        m_wait = 0;
        m_ena  = 1'b0;
        m_addr = '0;
        m_data = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        pipe_valid = 1'b0;
        slow_valid = 1'b0;
        #1;
        chk({tag, "_ena"},   32'(rf_wr_ena),  32'd0);
        chk({tag, "_addr"},  32'(rf_wr_addr), 32'd0);
        chk({tag, "_data"},  rf_wr_data,      32'd0);
        chk({tag, "_busy"},  32'(init_busy),  32'd1);
        chk({tag, "_stall"}, 32'(pipe_stall), 32'd1);
        chk({tag, "_ready"}, 32'(slow_ready), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: check handshake outputs mid-cycle, advance model, check write port after the edge.
    task automatic cycle();
        bit forced, take_pipe, take_slow;
        forced = 0; take_pipe = 0; take_slow = 0;
        @(negedge clk);
        if (m_init) begin
            chk("init_busy",  32'(init_busy),  32'd1);
            chk("init_stall", 32'(pipe_stall), 32'd1);
            chk("init_ready", 32'(slow_ready), 32'd0);
            m_ena  = 1'b1;
            m_addr = 5'(m_fill);
            m_data = '0;
            rf_model[m_fill] = '0;
            m_fill++;
            if (m_fill == 32) m_init = 1'b0;
        end else begin
            forced    = slow_valid && (m_wait >= LIMIT);
            take_pipe = pipe_valid && !forced;
            take_slow = slow_valid && !take_pipe;
            chk("run_busy",  32'(init_busy),  32'd0);
            chk("run_stall", 32'(pipe_stall), 32'(forced));
            chk("run_ready", 32'(slow_ready), 32'(take_slow));
            if (pipe_stall) stall_seen++;
            if (take_pipe || take_slow) begin
                m_addr = take_pipe ? pipe_rd : slow_rd;
                m_data = take_pipe ? pipe_data : slow_data;
                m_ena  = (m_addr != 5'd0);
                if (m_ena) rf_model[m_addr] = m_data;
            end else begin
                m_ena = 1'b0;
            end
            m_wait = (slow_valid && !take_slow) ? m_wait + 1 : 0;
        end
        @(posedge clk);
        #1;
        chk("wr_ena",  32'(rf_wr_ena),  32'(m_ena));
        chk("wr_addr", 32'(rf_wr_addr), 32'(m_addr));
        chk("wr_data", rf_wr_data,      m_data);
        if (take_slow) slow_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pipe_valid = 1'b0; pipe_rd = '0; pipe_data = '0;
        slow_valid = 1'b0; slow_rd = '0; slow_data = '0;
        stall_seen = 0;
        for (int i = 0; i < 32; i++) rf_model[i] = 32'hBAD0_0000 | 32'(i);
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Zero-fill with random requests that must be ignored.
        for (int i = 0; i < 31; i++) begin
            pipe_valid = 1'($urandom);
            pipe_rd    = 5'($urandom);
            pipe_data  = $urandom;
            cycle();
        end
        chk("fill_last_addr", 32'(rf_wr_addr), 32'd31);
        pipe_valid = 1'b0;
        cycle();
        chk("post_fill_idle", 32'(rf_wr_ena), 32'd0);

        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        cycle();
        chk("pipe_x5_data", rf_wr_data, 32'hDEADBEEF);
        pipe_valid = 1'b0;
        cycle();

        // Continuous contention: slow source must be forced in after LIMIT denials.
        stall_seen = 0;
        pipe_valid = 1'b1; pipe_rd = 5'd9; pipe_data = 32'h0000_0009;
        slow_valid = 1'b1; slow_rd = 5'd7; slow_data = 32'h12345678;
        for (int i = 0; i < LIMIT + 3; i++) begin
            if (i == LIMIT + 1) chk("forced_slow_addr", 32'(rf_wr_addr), 32'd7);
            cycle();
        end
        chk("forced_stall_count", 32'(stall_seen), 32'd1);
        chk("rf_x7", rf_model[7], 32'h12345678);

        pipe_rd = 5'd0; pipe_data = 32'hFFFFFFFF;
        cycle();
        chk("x0_no_write", 32'(rf_wr_ena), 32'd0);
        chk("rf_x0", rf_model[0], 32'hBAD0_0000);
        pipe_valid = 1'b0;

        stall_seen = 0;
        slow_valid = 1'b1; slow_rd = 5'd31; slow_data = 32'h1;
        cycle();
        cycle();
        chk("slow_only_stall", 32'(stall_seen), 32'd0);

        // Random traffic; slow requests held stable until accepted.
        for (int i = 0; i < 400; i++) begin
            pipe_valid = ($urandom_range(0, 3) != 0);
            pipe_rd    = 5'($urandom);
            pipe_data  = $urandom;
            if (!slow_valid && $urandom_range(0, 2) == 0) begin
                slow_valid = 1'b1;
                slow_rd    = 5'($urandom);
                slow_data  = $urandom;
            end
            cycle();
        end

        // Reset in the middle of the fill, then a full restart.
        do_reset("reset2");
        for (int i = 0; i < 12; i++) cycle();
        chk("pre_reset_addr", 32'(rf_wr_addr), 32'd12);
        do_reset("midfill");
        for (int i = 0; i < 31; i++) begin
            if (i == 0) begin
                pipe_valid = 1'b1; pipe_rd = 5'd3; pipe_data = 32'hAAAA5555;
            end
            cycle();
            if (i == 0) chk("restart_addr1", 32'(rf_wr_addr), 32'd1);
        end
        pipe_valid = 1'b0;
        cycle();
        chk("restart_done_busy", 32'(init_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
